ram_banked: RTL and testbench

RAM_BANKED -- requirements
Module: ram_banked

---
 rtl/ram_pkg.sv | 11 +
 rtl/ram_banked_if.sv | 27 ++
 rtl/ram_rd_pipe.sv | 43 ++++
 rtl/ram_banked.sv | 145 ++++++++++++++
 tb/tb_ram_banked.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/ram_pkg.sv
// Shared types and limits for the banked RAM.
package ram_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } ram_state_e;

  localparam int RD_LATENCY_MAX = 4;

endpackage

// File: rtl/ram_banked_if.sv
// Request/response bundle for ram_banked; the bench drives the master side.
interface ram_banked_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6,
  parameter int CHANNELS   = 1
);
  logic                           en;
  logic                           wr_en;
  logic [CHANNELS-1:0]            wr_mask;
  logic [ADDR_WIDTH-1:0]          address_wr;
  logic [CHANNELS*DATA_WIDTH-1:0] din;
  logic                           rd_en;
  logic [ADDR_WIDTH-1:0]          address_rd;
  logic [CHANNELS*DATA_WIDTH-1:0] dout;
  logic                           dout_valid;
  logic                           init_busy;

  modport master (
    output en, wr_en, wr_mask, address_wr, din, rd_en, address_rd,
    input  dout, dout_valid, init_busy
  );

  modport slave (
    input  en, wr_en, wr_mask, address_wr, din, rd_en, address_rd,
    output dout, dout_valid, init_busy
  );
endinterface

// File: rtl/ram_rd_pipe.sv
// Read-latency delay line for data plus valid; data is zeroed whenever valid is low.
module ram_rd_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_i,
  input  logic             valid_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o
);

  generate
    if (STAGES == 0) begin : g_passthru
      logic unused_clk_rst;
      assign unused_clk_rst = &{1'b0, clk, rst};
      assign data_o  = valid_i ? data_i : '0;
      assign valid_o = valid_i;
    end else begin : g_shift
      logic [WIDTH-1:0]  data_q [STAGES];
      logic [STAGES-1:0] valid_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          valid_q <= '0;
          for (int i = 0; i < STAGES; i++) data_q[i] <= '0;
        end else begin
          valid_q[0] <= valid_i;
          data_q[0]  <= valid_i ? data_i : '0;
          for (int i = 1; i < STAGES; i++) begin
            valid_q[i] <= valid_q[i-1];
            data_q[i]  <= data_q[i-1];
          end
        end
      end

      assign data_o  = data_q[STAGES-1];
      assign valid_o = valid_q[STAGES-1];
    end
  endgenerate

endmodule

// File: rtl/ram_banked.sv
// Multi-lane RAM with self-clear after reset and configurable read latency.
// Optional macro RAM_BYPASS_EN forwards same-cycle write data to a colliding read.
module ram_banked
  import ram_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int WORDS      = 64,
  parameter int ADDR_WIDTH = 6,
  parameter int CHANNELS   = 1,
  parameter int RD_LATENCY = 1
) (
  input logic         clk,
  input logic         rst,
  ram_banked_if.slave bus
);

  localparam int DW    = CHANNELS * DATA_WIDTH;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int LAT   = (RD_LATENCY < 1) ? 1 :
                         ((RD_LATENCY > RD_LATENCY_MAX) ? RD_LATENCY_MAX : RD_LATENCY);
  localparam logic [ADDR_WIDTH:0]   WORDS_L   = (ADDR_WIDTH+1)'(WORDS);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(WORDS - 1);

  ram_state_e            state_q;
  logic [ADDR_WIDTH-1:0] init_ptr_q;
  logic                  init_busy_q;

  logic                  wr_acc, rd_acc, wr_in_range, rd_in_range;
  logic [CHANNELS-1:0]   mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_waddr_d;
  logic [DW-1:0]         mem_wdata_d;
  logic [DW-1:0]         rd_raw;
  logic [DW-1:0]         s1_data;
  logic                  s1_valid_q;
  logic                  s1_zero_q;

  assign wr_in_range = ({1'b0, bus.address_wr} < WORDS_L);
  assign rd_in_range = ({1'b0, bus.address_rd} < WORDS_L);
  assign wr_acc      = (state_q == RUN) && bus.en && bus.wr_en;
  assign rd_acc      = (state_q == RUN) && bus.en && bus.rd_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= INIT;
      init_ptr_q  <= '0;
      init_busy_q <= 1'b1;
    end else begin
      case (state_q)
        INIT: begin
          if (init_ptr_q == LAST_ADDR) begin
            state_q     <= RUN;
            init_busy_q <= 1'b0;
          end else begin
            init_ptr_q <= init_ptr_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // The clear sweep owns the write port until RUN.
  always_comb begin
    mem_we_d    = '0;
    mem_waddr_d = bus.address_wr;
    mem_wdata_d = bus.din;
    if (state_q == INIT) begin
      mem_we_d    = '1;
      mem_waddr_d = init_ptr_q;
      mem_wdata_d = '0;
    end else if (wr_acc && wr_in_range) begin
      mem_we_d    = bus.wr_mask;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_lane
      logic [DATA_WIDTH-1:0] mem_q [WORDS];
      logic [DATA_WIDTH-1:0] rd_raw_q;

      always_ff @(posedge clk) begin
        if (mem_we_d[gi])
          mem_q[mem_waddr_d[IDX_W-1:0]] <= mem_wdata_d[gi*DATA_WIDTH +: DATA_WIDTH];
        rd_raw_q <= mem_q[bus.address_rd[IDX_W-1:0]];
      end

      assign rd_raw[gi*DATA_WIDTH +: DATA_WIDTH] = rd_raw_q;
    end
  endgenerate

`ifdef RAM_BYPASS_EN
  logic [CHANNELS-1:0] s1_fwd_q;
  logic [DW-1:0]       s1_din_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_zero_q  <= 1'b0;
`ifdef RAM_BYPASS_EN
      s1_fwd_q   <= '0;
      s1_din_q   <= '0;
`endif
    end else begin
      s1_valid_q <= rd_acc;
      s1_zero_q  <= !rd_in_range;
`ifdef RAM_BYPASS_EN
      s1_fwd_q   <= (wr_acc && wr_in_range && (bus.address_wr == bus.address_rd))
                    ? bus.wr_mask : '0;
      s1_din_q   <= bus.din;
`endif
    end
  end

  // RAM output is read-before-write, so without forwarding a collision sees old data.
  always_comb begin
    s1_data = rd_raw;
`ifdef RAM_BYPASS_EN
    for (int i = 0; i < CHANNELS; i++)
      if (s1_fwd_q[i]) s1_data[i*DATA_WIDTH +: DATA_WIDTH] = s1_din_q[i*DATA_WIDTH +: DATA_WIDTH];
`endif
    if (s1_zero_q) s1_data = '0;
  end

  logic [DW-1:0] dout_w;
  logic          dout_valid_w;

  ram_rd_pipe #(
    .WIDTH  (DW),
    .STAGES (LAT - 1)
  ) u_rd_pipe (
    .clk     (clk),
    .rst     (rst),
    .data_i  (s1_data),
    .valid_i (s1_valid_q),
    .data_o  (dout_w),
    .valid_o (dout_valid_w)
  );

  assign bus.dout       = dout_w;
  assign bus.dout_valid = dout_valid_w;
  assign bus.init_busy  = init_busy_q;

endmodule

// File: tb/tb_ram_banked.sv
// Directed bench for ram_banked: 2 lanes, 64 words, 7-bit address, latency 3.
module tb_ram_banked;

  localparam int DW  = 8;
  localparam int CH  = 2;
  localparam int AW  = 7;
  localparam int LAT = 3;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  ram_banked_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CHANNELS(CH)) bus ();

  ram_banked #(
    .DATA_WIDTH (DW),
    .WORDS      (64),
    .ADDR_WIDTH (AW),
    .CHANNELS   (CH),
    .RD_LATENCY (LAT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("chk %s got=%h exp=%h ok", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [AW-1:0] addr, input logic [15:0] data, input logic [1:0] mask);
    bus.en = 1'b1; bus.wr_en = 1'b1; bus.address_wr = addr; bus.din = data; bus.wr_mask = mask;
    tick();
    bus.wr_en = 1'b0;
  endtask

  // Any write signals already set up are presented in the same cycle as the read.
  task automatic do_read(input logic [AW-1:0] addr, input logic [15:0] exp, input string tag);
    bus.en = 1'b1; bus.rd_en = 1'b1; bus.address_rd = addr;
    tick();
    bus.rd_en = 1'b0; bus.wr_en = 1'b0;
    for (int i = 1; i < LAT; i++) begin
      check_val({tag, "_early_valid"}, 32'(bus.dout_valid), 32'h0);
      tick();
    end
    check_val({tag, "_valid"}, 32'(bus.dout_valid), 32'h1);
    check_val({tag, "_data"}, 32'(bus.dout), 32'(exp));
    tick();
    check_val({tag, "_idle_valid"}, 32'(bus.dout_valid), 32'h0);
    check_val({tag, "_idle_zero"}, 32'(bus.dout), 32'h0);
  endtask

  task automatic wait_init(input string tag);
    int  n    = 0;
    bit  seen = 1'b0;
    while (bus.init_busy && n < 200) begin
      tick();
      n++;
      if (bus.dout_valid) seen = 1'b1;
    end
    check_val({tag, "_cycles"}, 32'(n), 32'd64);
    check_val({tag, "_no_valid"}, 32'(seen), 32'h0);
  endtask

  initial begin
    rst = 1'b1;
    bus.en = 1'b0; bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.wr_mask = '0;
    bus.address_wr = '0; bus.address_rd = '0; bus.din = '0;
    tick(); tick();
    check_val("rst_init_busy", 32'(bus.init_busy), 32'h1);
    check_val("rst_valid", 32'(bus.dout_valid), 32'h0);
    check_val("rst_dout", 32'(bus.dout), 32'h0);

    // Requests held during the clear must be ignored.
    bus.en = 1'b1; bus.wr_en = 1'b1; bus.address_wr = 7'd0; bus.din = 16'hFFFF; bus.wr_mask = 2'b11;
    bus.rd_en = 1'b1; bus.address_rd = 7'd0;
    rst = 1'b0;
    wait_init("init1");
    bus.wr_en = 1'b0; bus.rd_en = 1'b0;

    do_read(7'd63, 16'h0000, "rd63_cleared");
    do_read(7'd0, 16'h0000, "rd0_init_wr_ignored");

    do_write(7'd5, 16'h00A5, 2'b11);
    do_read(7'd5, 16'h00A5, "rd5_a5");

    do_write(7'd9, 16'h1122, 2'b11);
    do_write(7'd9, 16'h3344, 2'b10);
    do_read(7'd9, 16'h3322, "rd9_masked");

    do_write(7'd100, 16'hBEEF, 2'b11);
    do_read(7'd100, 16'h0000, "rd100_oor");
    do_read(7'd36, 16'h0000, "rd36_alias_untouched");

    do_write(7'd7, 16'h0010, 2'b11);
    bus.wr_en = 1'b1; bus.address_wr = 7'd7; bus.din = 16'h0020; bus.wr_mask = 2'b11;
`ifdef RAM_BYPASS_EN
    do_read(7'd7, 16'h0020, "collide_full");
`else
    do_read(7'd7, 16'h0010, "collide_full");
`endif
    do_read(7'd7, 16'h0020, "rd7_after");
    bus.wr_en = 1'b1; bus.address_wr = 7'd7; bus.din = 16'h5566; bus.wr_mask = 2'b01;
`ifdef RAM_BYPASS_EN
    do_read(7'd7, 16'h0066, "collide_lane0");
`else
    do_read(7'd7, 16'h0020, "collide_lane0");
`endif
    do_read(7'd7, 16'h0066, "rd7_lane0");

    bus.en = 1'b0; bus.wr_en = 1'b1; bus.rd_en = 1'b1;
    bus.address_wr = 7'd5; bus.address_rd = 7'd5; bus.din = 16'hFFFF; bus.wr_mask = 2'b11;
    tick();
    bus.wr_en = 1'b0; bus.rd_en = 1'b0;
    for (int i = 0; i < LAT + 1; i++) begin
      check_val("en0_no_valid", 32'(bus.dout_valid), 32'h0);
      tick();
    end
    do_read(7'd5, 16'h00A5, "rd5_after_en0");

    // Back-to-back reads emerge on consecutive cycles.
    bus.en = 1'b1; bus.rd_en = 1'b1; bus.address_rd = 7'd5;
    tick(); bus.address_rd = 7'd9;
    tick(); bus.address_rd = 7'd7;
    tick(); bus.rd_en = 1'b0;
    check_val("b2b_0", 32'(bus.dout), 32'h00A5);
    tick();
    check_val("b2b_1", 32'(bus.dout), 32'h3322);
    tick();
    check_val("b2b_2", 32'(bus.dout), 32'h0066);
    check_val("b2b_2_valid", 32'(bus.dout_valid), 32'h1);

    tick();
    bus.rd_en = 1'b1; bus.address_rd = 7'd5;
    tick(); bus.address_rd = 7'd9;
    tick(); bus.rd_en = 1'b0;
    rst = 1'b1;
    #1;
    check_val("midrst_valid", 32'(bus.dout_valid), 32'h0);
    check_val("midrst_dout", 32'(bus.dout), 32'h0);
    check_val("midrst_init_busy", 32'(bus.init_busy), 32'h1);
    tick();
    rst = 1'b0;
    wait_init("init2");
    do_read(7'd5, 16'h0000, "rd5_recleared");
    do_read(7'd0, 16'h0000, "rd0_recleared");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
